// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared constants and redirect state type for the branch resolve unit
package branch_pkg;
  localparam logic [31:0] PC_INCR = 32'd4;
  localparam int          CNT_W   = 32;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } redirect_state_t;
endpackage

// File: rtl/branch_perf_counter.sv
// rtl/branch_perf_counter.sv - enabled, saturating event counter with async reset
module branch_perf_counter
  import branch_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch/jump resolution, redirect and flush generation
// Performance counters are built only when BRANCH_PERF_EN is defined.
module branch_resolve_unit
  import branch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic        BneE,
  input  logic        ZeroE,
  input  logic        PredTakenE,
  input  logic        StallE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCTargetE,
  output logic        RedirectF,
  output logic [31:0] RedirectPCF,
  output logic        FlushD,
  output logic        FlushE,
  output logic [31:0] BranchCnt,
  output logic [31:0] MispredCnt
);

  redirect_state_t state, state_next;
  logic [31:0]     pc_next;
  logic [31:0]     correct_pc;
  logic            resolve;
  logic            taken;
  logic            mispredict;

  always_comb begin
    state_next = IDLE;
    pc_next    = RedirectPCF;
    correct_pc = PCE + PC_INCR;
    RedirectF  = (state == REDIRECT);

    // The EX instruction is wrong-path while a redirect is in flight.
    resolve    = (BranchE | JumpE) & ~StallE & ~RedirectF;
    taken      = JumpE | (BranchE & (ZeroE ^ BneE));
    if (taken) begin
      correct_pc = PCTargetE;
    end
    mispredict = resolve & (taken != PredTakenE);

    case (state)
      IDLE: begin
        if (mispredict) begin
          state_next = REDIRECT;
          pc_next    = correct_pc;
        end
      end
      REDIRECT: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      RedirectPCF <= 32'h0;
    end else begin
      state       <= state_next;
      RedirectPCF <= pc_next;
    end
  end

  assign FlushD = RedirectF;
  assign FlushE = RedirectF;

`ifdef BRANCH_PERF_EN
  branch_perf_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (resolve),
    .count (BranchCnt)
  );

  branch_perf_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (mispredict),
    .count (MispredCnt)
  );
`else
  assign BranchCnt  = 32'h0;
  assign MispredCnt = 32'h0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - randomized and directed bench for branch_resolve_unit against a behavioural model
module tb_branch_resolve_unit;

`ifdef BRANCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        BranchE = 1'b0, JumpE = 1'b0, BneE = 1'b0, ZeroE = 1'b0;
  logic        PredTakenE = 1'b0, StallE = 1'b0;
  logic [31:0] PCE = 32'h0, PCTargetE = 32'h0;
  logic        RedirectF, FlushD, FlushE;
  logic [31:0] RedirectPCF, BranchCnt, MispredCnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state: what the outputs must show after each edge.
  logic        m_redirect = 1'b0;
  logic [31:0] m_pc = 32'h0;
  longint      m_bc = 0, m_mc = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk         (clk),
    .reset       (reset),
    .BranchE     (BranchE),
    .JumpE       (JumpE),
    .BneE        (BneE),
    .ZeroE       (ZeroE),
    .PredTakenE  (PredTakenE),
    .StallE      (StallE),
    .PCE         (PCE),
    .PCTargetE   (PCTargetE),
    .RedirectF   (RedirectF),
    .RedirectPCF (RedirectPCF),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .BranchCnt   (BranchCnt),
    .MispredCnt  (MispredCnt)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_redirect = 1'b0;
      m_pc       = 32'h0;
      m_bc       = 0;
      m_mc       = 0;
    end else begin
      bit          is_ctl, is_taken, counted, wrong;
      logic [31:0] dest;
      is_ctl = (BranchE || JumpE) && !StallE && !m_redirect;
      if (JumpE)        is_taken = 1'b1;
      else if (BneE)    is_taken = BranchE && !ZeroE;
      else              is_taken = BranchE && ZeroE;
      dest    = is_taken ? PCTargetE : 32'((64'(PCE) + 64'd4) % 64'h1_0000_0000);
      counted = is_ctl;
      wrong   = is_ctl && (is_taken != PredTakenE);
      if (PERF && counted && m_bc < 64'hFFFF_FFFF) m_bc++;
      if (PERF && wrong && m_mc < 64'hFFFF_FFFF) m_mc++;
      m_redirect = wrong;
      if (wrong) m_pc = dest;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_RedirectF", {31'h0, RedirectF}, {31'h0, m_redirect});
      chk("model_FlushD", {31'h0, FlushD}, {31'h0, m_redirect});
      chk("model_FlushE", {31'h0, FlushE}, {31'h0, m_redirect});
      chk("model_RedirectPCF", RedirectPCF, m_pc);
      chk("model_BranchCnt", BranchCnt, m_bc[31:0]);
      chk("model_MispredCnt", MispredCnt, m_mc[31:0]);
    end
  end

  task automatic drive(input logic b, input logic j, input logic bne, input logic z,
                       input logic p, input logic s, input logic [31:0] pc,
                       input logic [31:0] tgt);
    BranchE = b; JumpE = j; BneE = bne; ZeroE = z;
    PredTakenE = p; StallE = s; PCE = pc; PCTargetE = tgt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic pin(string name, logic r, logic [31:0] pc, int bc, int mc);
    chk({name, "_RedirectF"}, {31'h0, RedirectF}, {31'h0, r});
    chk({name, "_Flush"}, {30'h0, FlushD, FlushE}, {30'h0, r, r});
    chk({name, "_RedirectPCF"}, RedirectPCF, pc);
    chk({name, "_BranchCnt"}, BranchCnt, PERF ? 32'(bc) : 32'h0);
    chk({name, "_MispredCnt"}, MispredCnt, PERF ? 32'(mc) : 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    pin("reset", 1'b0, 32'h0, 0, 0);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // BEQ taken, predicted not-taken, first edge after reset release.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h80);
    pin("beq_mis", 1'b1, 32'h80, 1, 1);
    idle();
    pin("beq_mis_after", 1'b0, 32'h80, 1, 1);

    // BNE not taken, predicted taken: fall-through.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h1F0);
    pin("bne_mis", 1'b1, 32'h204, 2, 2);
    idle();

    // Correct prediction.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h40);
    pin("beq_ok", 1'b0, 32'h204, 3, 2);

    // Stalled mispredicting branch resolves once, then is ignored during redirect.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h340);
      pin("stall_hold", 1'b0, 32'h204, 3, 2);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h340);
    pin("stall_release", 1'b1, 32'h340, 4, 3);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h340);
    pin("wrong_path_ignored", 1'b0, 32'h340, 4, 3);
    idle();

    // Back-to-back mispredicts: second one is wrong-path.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h480);
    pin("b2b_first", 1'b1, 32'h480, 5, 4);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h404, 32'h500);
    pin("b2b_second", 1'b0, 32'h480, 5, 4);

    // Fall-through wraps at the top of the address space.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h10);
    pin("wrap", 1'b1, 32'h0, 6, 5);
    idle();

    // BranchE and JumpE together act as a jump.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h600, 32'h700);
    pin("jal_and_branch", 1'b1, 32'h700, 7, 6);
    idle();

    // Reset mid-redirect clears everything without waiting for a clock.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h800, 32'h880);
    pin("pre_reset", 1'b1, 32'h880, 8, 7);
    #2 reset = 1'b1;
    #1 pin("async_reset", 1'b0, 32'h0, 0, 0);
    @(negedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      reset      = ($urandom_range(0, 299) == 0);
      BranchE    = ($urandom_range(0, 2) == 0);
      JumpE      = ($urandom_range(0, 5) == 0);
      BneE       = 1'($urandom);
      ZeroE      = 1'($urandom);
      PredTakenE = 1'($urandom);
      StallE     = ($urandom_range(0, 3) == 0);
      PCE        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      PCTargetE  = $urandom & 32'hFFFF_FFFC;
    end
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state rising-edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-003 SHALL have port BranchE, input, 1 bit: conditional branch (BEQ/BNE) occupies EX.
REQ-004 SHALL have port JumpE, input, 1 bit: JAL occupies EX; unconditionally taken.
REQ-005 SHALL have port BneE, input, 1 bit: 1 = BNE (taken on ~ZeroE), 0 = BEQ (taken on ZeroE).
REQ-006 SHALL have port ZeroE, input, 1 bit: ALU zero flag for the EX instruction (SrcA - SrcB == 0).
REQ-007 SHALL have port PredTakenE, input, 1 bit: static prediction carried from decode (backward taken, forward not-taken; JAL taken).
REQ-008 SHALL have port StallE, input, 1 bit: EX stage held this cycle.
REQ-009 SHALL have ports PCE and PCTargetE, input, 32 bits each: EX-stage PC; computed branch/jump target.
REQ-010 SHALL have port RedirectF, output, 1 bit: fetch PC load strobe.
REQ-011 SHALL have port RedirectPCF, output, 32 bits: corrected fetch PC.
REQ-012 SHALL have ports FlushD and FlushE, output, 1 bit each: squash IF/ID and ID/EX registers.
REQ-013 SHALL have ports BranchCnt and MispredCnt, output, 32 bits each: performance counters.

Function
REQ-014 Resolve event SHALL occur in cycle N iff (BranchE | JumpE) & ~StallE & ~RedirectF.
REQ-015 Actual-taken SHALL be JumpE | (BranchE & (ZeroE ^ BneE)).
REQ-016 Mispredict SHALL be resolve event & (actual-taken != PredTakenE).
REQ-017 Correct PC SHALL be PCTargetE when actual-taken, else PCE + 4 (32-bit, modulo 2^32 wrap).
REQ-018 On mispredict in cycle N, RedirectF, FlushD and FlushE SHALL all be 1 in cycle N+1 only; RedirectPCF SHALL hold the correct PC in cycle N+1.
REQ-019 Correct prediction SHALL produce no redirect and no flush.
REQ-020 In the cycle RedirectF = 1, the EX instruction is wrong-path; BranchE/JumpE SHALL be ignored (no resolve, no count).
REQ-021 While StallE = 1, no resolve SHALL occur; a held branch SHALL resolve exactly once, in the first cycle StallE = 0.
REQ-022 RedirectPCF SHALL retain its last value when RedirectF = 0.
REQ-023 BranchE and JumpE both 1 SHALL be treated as a jump.
REQ-024 Redirect register states SHALL be IDLE (RedirectF = 0) and REDIRECT (RedirectF = 1). IDLE->REDIRECT on mispredict; REDIRECT->IDLE unconditionally after one cycle. Back-to-back redirects are impossible per REQ-020.

Reset
REQ-025 While reset = 1, RedirectF, FlushD, FlushE SHALL be 0, RedirectPCF 32'h0, BranchCnt and MispredCnt 0, state IDLE.
REQ-026 Reset asserted mid-redirect SHALL clear the pending redirect immediately. First resolve SHALL be possible in the first clock edge after reset deasserts.

Configuration
REQ-027 Macro BRANCH_PERF_EN defined: BranchCnt SHALL increment on every resolve event. MispredCnt SHALL increment on every mispredict. Both saturate at 32'hFFFF_FFFF.
REQ-028 Macro BRANCH_PERF_EN undefined: counters SHALL not be built; BranchCnt and MispredCnt SHALL be tied to 32'h0; ports remain.

Structure
REQ-029 Shared package branch_pkg SHALL hold constant PC_INCR = 32'd4, the redirect state enum (IDLE, REDIRECT), and counter width constant CNT_W = 32.
REQ-030 Counters SHALL be one reused sub-module branch_perf_counter (enable, saturate, async reset), instantiated twice under BRANCH_PERF_EN.

Verification
REQ-031 BEQ, ZeroE = 1, PredTakenE = 0, PCE = 32'h100, PCTargetE = 32'h80 -> next cycle RedirectF = FlushD = FlushE = 1, RedirectPCF = 32'h80; following cycle all 0.
REQ-032 BNE, ZeroE = 1, PredTakenE = 1, PCE = 32'h200 -> next cycle RedirectPCF = 32'h204, flushes 1; MispredCnt = 1 and BranchCnt = 1 when enabled.
REQ-033 BEQ, ZeroE = 1, PredTakenE = 1, PCTargetE = 32'h40 -> no redirect/flush; BranchCnt increments, MispredCnt unchanged.
REQ-034 Mispredicting BEQ with StallE = 1 for 3 cycles, then 0 -> exactly one redirect, in the cycle after StallE falls; BranchCnt += 1.
REQ-035 Mispredict in cycle N with a mispredicting BranchE in N+1 -> single redirect in N+1, none in N+2. Assert reset during N+1 -> RedirectF drops to 0 asynchronously.
REQ-036 PCE = 32'hFFFF_FFFC, not-taken, PredTakenE = 1 -> RedirectPCF = 32'h0 (wrap).
